// File: rtl/multi_edge_detector_if.sv
// Signal bundle for multi_edge_detector; the count bus exists only when EDGE_COUNT_EN is defined.
// Inputs: raw levels, per-channel mode and clear. Outputs: pulses, debounced levels, sticky flags.
interface multi_edge_detector_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]       level;
    logic [2*N_CH-1:0]     mode;
    logic [N_CH-1:0]       clr;
    logic [N_CH-1:0]       p_edge;
    logic [N_CH-1:0]       n_edge;
    logic [N_CH-1:0]       stable;
    logic [N_CH-1:0]       pending;
    logic                  irq;
`ifdef EDGE_COUNT_EN
    logic [N_CH*CNT_W-1:0] count;
`endif

    modport slave (
`ifdef EDGE_COUNT_EN
        output count,
`endif
        input  level, mode, clr,
        output p_edge, n_edge, stable, pending, irq
    );

    modport master (
`ifdef EDGE_COUNT_EN
        input  count,
`endif
        output level, mode, clr,
        input  p_edge, n_edge, stable, pending, irq
    );
endinterface

// File: rtl/multi_edge_detector.sv
// Per-channel synchronise + debounce + edge pulse, sticky pending flags and irq; event counters under EDGE_COUNT_EN.
// Latency: a held level change pulses p_edge/n_edge DB_CYCLES+2 edges after it is first sampled.
// No backpressure: pulses are fire-and-forget, pending holds until clr.
module multi_edge_detector #(
    parameter int N_CH      = 4,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    multi_edge_detector_if.slave bus
);
    localparam int             DBW    = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES);

    typedef enum logic [1:0] {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO} state_t;

    logic [N_CH-1:0] s1_q, s2_q;
    state_t          state_q [N_CH];
    state_t          state_d [N_CH];
    logic [DBW-1:0]  db_q    [N_CH];
    logic [DBW-1:0]  db_d    [N_CH];
    logic [N_CH-1:0] stable_q, stable_d;
    logic [N_CH-1:0] p_edge_q, p_edge_d;
    logic [N_CH-1:0] n_edge_q, n_edge_d;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] event_w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            p_edge_q  <= '0;
            n_edge_q  <= '0;
            pending_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE_LO;
                db_q[i]    <= '0;
            end
        end else begin
            s1_q      <= bus.level;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            p_edge_q  <= p_edge_d;
            n_edge_q  <= n_edge_d;
            pending_q <= pending_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                db_q[i]    <= db_d[i];
            end
        end
    end

    // A CHK state falls back to its IDLE as soon as s2 agrees with stable again.
    always_comb begin
        stable_d = stable_q;
        p_edge_d = '0;
        n_edge_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            db_d[i]    = db_q[i];
            unique case (state_q[i])
                IDLE_LO: begin
                    if (s2_q[i]) begin
                        state_d[i] = CHK_HI;
                        db_d[i]    = DBW'(1);
                    end
                end
                CHK_HI: begin
                    if (!s2_q[i]) begin
                        state_d[i] = IDLE_LO;
                        db_d[i]    = '0;
                    end else if (db_q[i] == DB_MAX) begin
                        state_d[i]  = IDLE_HI;
                        db_d[i]     = '0;
                        stable_d[i] = 1'b1;
                        p_edge_d[i] = 1'b1;
                    end else begin
                        db_d[i] = db_q[i] + DBW'(1);
                    end
                end
                IDLE_HI: begin
                    if (!s2_q[i]) begin
                        state_d[i] = CHK_LO;
                        db_d[i]    = DBW'(1);
                    end
                end
                CHK_LO: begin
                    if (s2_q[i]) begin
                        state_d[i] = IDLE_HI;
                        db_d[i]    = '0;
                    end else if (db_q[i] == DB_MAX) begin
                        state_d[i]  = IDLE_LO;
                        db_d[i]     = '0;
                        stable_d[i] = 1'b0;
                        n_edge_d[i] = 1'b1;
                    end else begin
                        db_d[i] = db_q[i] + DBW'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE_LO;
                    db_d[i]    = '0;
                end
            endcase
        end
    end

    // Mode only qualifies which pulses count as events; set wins over a same-cycle clear.
    always_comb begin
        event_w = '0;
        for (int i = 0; i < N_CH; i++) begin
            event_w[i] = (p_edge_q[i] & bus.mode[2*i]) | (n_edge_q[i] & bus.mode[2*i+1]);
        end
        pending_d = (pending_q & ~bus.clr) | event_w;
    end

    assign bus.p_edge  = p_edge_q;
    assign bus.n_edge  = n_edge_q;
    assign bus.stable  = stable_q;
    assign bus.pending = pending_q;
    assign bus.irq     = |pending_q;

`ifdef EDGE_COUNT_EN
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    // Saturating counters; clear with a coincident event restarts at 1.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.clr[i]) begin
                cnt_d[i] = event_w[i] ? CNT_W'(1) : '0;
            end else if (event_w[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
        assign bus.count[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif
endmodule
